aes_inv_cipher_ctrl: RTL and testbench
======================================

# aes_inv_cipher_ctrl

Iterative AES-128 inverse-cipher controller. It sequences one shared `inv_subbytes` datapath instance, plus internal InvShiftRows, AddRoundKey and InvMixColumns logic, through the 10 decryption rounds at one round per clock. Round keys come from an external key store addressed by this block. It sits between the ciphertext source and the plaintext sink in the decrypt path.

## Interface
- No parameters. Fixed at AES-128: 128-bit block, 10 rounds.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `start`  in  1  begin decryption of `in`.
  - Sampled only in IDLE.
  - Ignored while `busy`=1.
- `in`  in  128  ciphertext block, sampled on the `start` edge.
  - Byte 0 = `in[127:120]`.
  - State byte s[r,c] = byte 4c+r (FIPS-197 column-major order).
- `rk`  in  128  round key selected by `rk_idx`; combinational, valid in the same cycle.
- `rk_idx`  out  4  round-key index requested; combinational from state.
- `busy`  out  1  high while a block is in flight.
- `done`  out  1  one-cycle pulse when `out` is updated.
- `out`  out  128  plaintext result, registered and held until the next completion.

## Operation
- States: IDLE, ROUND, FINAL.
- Internal registers:
  - `st[127:0]`: working state.
  - `cnt[3:0]`: round counter.
- IDLE
  - `rk_idx`=10, `busy`=0.
  - On `start`=1: `st` <= `in` ^ `rk` (initial AddRoundKey with rk10), `cnt` <= 9, go to ROUND.
- ROUND
  - `rk_idx`=`cnt`, `busy`=1.
  - `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ `rk`).
  - `cnt` <= `cnt`-1.
  - If `cnt`==1, go to FINAL; otherwise stay in ROUND.
- FINAL
  - `rk_idx`=0, `busy`=1.
  - `out` <= InvSubBytes(InvShiftRows(`st`)) ^ `rk`.
  - `done` <= 1; go to IDLE.
- `done` is a registered pulse. It is high for exactly the one cycle after the FINAL edge; otherwise it is 0.
- Key index sequence over one block: 10, 9, 8, …, 1, 0. Each index is presented for exactly one cycle.
- InvShiftRows: row r is rotated right by r byte positions (rows 1, 2, 3 shift by 1, 2, 3 columns).
- InvMixColumns, per column [a0..a3]:
  - b0 = 0e·a0 ^ 0b·a1 ^ 0d·a2 ^ 09·a3, with coefficients rotating for b1..b3.
  - Multiplication is in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11b), built from an xtime chain.
- All XORs are 128-bit, with no carries.
- `start` while `busy`=1 is ignored. The in-flight block is unaffected and no queueing occurs.
- `start` in the same cycle that `done` is high is legal: the FSM is in IDLE, so the new block is accepted.
- `rst`=1 in any state, including mid-operation:
  - Next cycle: state IDLE, `busy`=0, `done`=0, `out`=0, `st`=0, `cnt`=0.
  - The partial block is discarded.
- `rk_idx`, `busy` and `done` are never X after reset; `rk_idx` reads 10 in IDLE.

## Timing
- Reset values: `out`=0, `done`=0, `busy`=0, `rk_idx`=10.
- Edge E0 samples `start`=1. ROUND occupies edges E1..E9; FINAL is edge E10.
- `out` is valid and `done`=1 in the cycle after E10, i.e. 11 clocks after the `start` edge.
- Throughput: back-to-back `start` pulses yield one block per 11 clocks.
- `busy`=1 from the cycle after E0 through the cycle after E9. It deasserts in the cycle in which `done`=1.
- Key-store timing: `rk` must settle combinationally from `rk_idx` within the same cycle. No key latency is tolerated.

## Test plan
- FIPS-197 C.1 decrypt:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f (bench holds the expanded table; rk10 = 13111d7fe3944a17f307a78b4d2b30c5), `in` = 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: `out` = 00112233445566778899aabbccddeeff, with `done` 11 clocks after `start`.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, `in` = 3925841d02dc09fbdc118597196a0b32.
  - Response: `out` = 3243f6a8885a308d313198a2e0370734.
  - Also check `rk_idx` steps 10→0, one value per cycle.
- Busy rejection:
  - Stimulus: start the C.1 block, then pulse `start` with a different `in` at E3.
  - Response: exactly one `done`; `out` = 00112233445566778899aabbccddeeff; `busy` drops as expected.
- Back-to-back:
  - Stimulus: assert `start` in the `done` cycle with the Appendix B ciphertext.
  - Response: second `done` exactly 11 clocks later with the correct plaintext; first `out` held until then.
- Reset mid-operation:
  - Stimulus: assert `rst` at E5 of a block.
  - Response: next cycle `busy`=0, `done`=0, `out`=0, `rk_idx`=10, and no `done` ever appears for that block.
  - A subsequent C.1 run decrypts correctly.
- Random regression: 1000 random key/ciphertext pairs against a software AES-128 model. Every `out` must match, with latency fixed at 11.

Source files
------------

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one decryption round per clock through a
// single shared InvSubBytes datapath, with round keys fetched from an external store.

module inv_subbytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        gf_mul = p;
    endfunction

    // Multiplicative inverse computed as x^254, which also maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] y;
        y = gf_mul(gf_mul(x, x), x);
        for (int i = 0; i < 5; i++) begin
            y = gf_mul(gf_mul(y, y), x);
        end
        gf_inv = gf_mul(y, y);
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a;
        a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        inv_sbox = gf_inv(a);
    endfunction

    // Byte-wise inverse S-box across the whole block
    always_comb begin
        dout = 128'h0;
        for (int i = 0; i < 16; i++) begin
            dout[8*i +: 8] = inv_sbox(din[8*i +: 8]);
        end
    end
endmodule

module aes_inv_cipher_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] rk,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done,
    output logic [127:0] out
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    state_t       state_r;
    logic [127:0] st_r;
    logic [3:0]   cnt_r;
    logic [127:0] out_r;
    logic         done_r;

    logic [127:0] isr_s;
    logic [127:0] isb_s;
    logic [127:0] ark_s;
    logic [127:0] imc_s;
    logic [3:0]   rk_idx_s;
    logic         busy_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] a);
        mul_9 = xtime(xtime(xtime(a))) ^ a;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] a);
        mul_b = xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] a);
        mul_d = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] a);
        mul_e = xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // Byte 4c+r sits at bits [127-8(4c+r) -: 8]; row r rotates right by r columns
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        inv_shift_rows = o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
            o[119 - 32*c -: 8] = mul_9(a0) ^ mul_e(a1) ^ mul_b(a2) ^ mul_d(a3);
            o[111 - 32*c -: 8] = mul_d(a0) ^ mul_9(a1) ^ mul_e(a2) ^ mul_b(a3);
            o[103 - 32*c -: 8] = mul_b(a0) ^ mul_d(a1) ^ mul_9(a2) ^ mul_e(a3);
        end
        inv_mix_columns = o;
    endfunction

    inv_subbytes u_inv_subbytes (
        .din  (isr_s),
        .dout (isb_s)
    );

    // Round datapath shared by ROUND and FINAL; FINAL simply skips InvMixColumns
    always_comb begin
        isr_s = inv_shift_rows(st_r);
        ark_s = isb_s ^ rk;
        imc_s = inv_mix_columns(ark_s);
    end

    // Key index and busy decode from the state register
    always_comb begin
        rk_idx_s = 4'd10;
        busy_s   = 1'b0;
        case (state_r)
            IDLE: begin
                rk_idx_s = 4'd10;
                busy_s   = 1'b0;
            end
            ROUND: begin
                rk_idx_s = cnt_r;
                busy_s   = 1'b1;
            end
            FINAL: begin
                rk_idx_s = 4'd0;
                busy_s   = 1'b1;
            end
            default: begin
                rk_idx_s = 4'd10;
                busy_s   = 1'b0;
            end
        endcase
    end

    // Round sequencer, working state and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            st_r    <= 128'h0;
            cnt_r   <= 4'd0;
            out_r   <= 128'h0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        st_r    <= in ^ rk;
                        cnt_r   <= 4'd9;
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    st_r  <= imc_s;
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r == 4'd1) begin
                        state_r <= FINAL;
                    end
                end
                FINAL: begin
                    out_r   <= ark_s;
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rk_idx = rk_idx_s;
    assign busy   = busy_s;
    assign done   = done_r;
    assign out    = out_r;
endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Scoreboard bench for aes_inv_cipher_ctrl: directed FIPS-197 vectors plus
// randomized blocks checked against a byte-level software AES-128 model.

module tb_aes_inv_cipher_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] in_blk;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;
    logic [127:0] out_blk;

    aes_inv_cipher_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .in     (in_blk),
        .rk     (rk),
        .rk_idx (rk_idx),
        .busy   (busy),
        .done   (done),
        .out    (out_blk)
    );

    always #5 clk = ~clk;

    // Key store: 11 round keys of the current block, addressed by the DUT
    logic [127:0] keys [16];
    assign rk = keys[rk_idx];

    logic [7:0]  sbox  [256];
    logic [7:0]  isbox [256];
    logic [31:0] w     [44];

    typedef struct {
        int           due;
        logic [127:0] pt;
    } exp_t;
    exp_t q[$];

    int           cyc      = 0;
    int           n_chk    = 0;
    int           n_fail   = 0;
    int           inflight = -1000;
    logic         rst_q;
    logic [127:0] exp_out  = 128'h0;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
        return (b << k) | (b >> (8 - k));
    endfunction

    // Forward S-box from brute-force inverses plus the affine map; inverse table by lookup
    task automatic init_tables();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    task automatic expand(input logic [127:0] key);
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher on a 16-byte array, byte 4c+r = s[r,c]
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ keys[10][127 - 8*i -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c + r] = s[4*((c - r + 4) % 4) + r];
            for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ keys[rnd][127 - 8*i -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = s[4*c + k];
                    s[4*c+0] = gmul(a[0],8'h0e) ^ gmul(a[1],8'h0b) ^ gmul(a[2],8'h0d) ^ gmul(a[3],8'h09);
                    s[4*c+1] = gmul(a[0],8'h09) ^ gmul(a[1],8'h0e) ^ gmul(a[2],8'h0b) ^ gmul(a[3],8'h0d);
                    s[4*c+2] = gmul(a[0],8'h0d) ^ gmul(a[1],8'h09) ^ gmul(a[2],8'h0e) ^ gmul(a[3],8'h0b);
                    s[4*c+3] = gmul(a[0],8'h0b) ^ gmul(a[1],8'h0d) ^ gmul(a[2],8'h09) ^ gmul(a[3],8'h0e);
                end
            end
        end
        res = 128'h0;
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Monitor: compares every cycle against the scoreboard and the in-flight schedule
    always @(negedge clk) begin
        logic       ed;
        int         e;
        logic [3:0] er;
        logic       eb;
        if (rst_q === 1'b1) begin
            q.delete();
            exp_out  = 128'h0;
            inflight = -1000;
        end
        ed = (q.size() > 0) && (q[0].due == cyc);
        chk("done", 128'(done), 128'(ed));
        if (ed) begin
            exp_out = q[0].pt;
            void'(q.pop_front());
        end
        chk("out", out_blk, exp_out);
        e = cyc - inflight;
        if (e >= 0 && e <= 9) begin
            er = 4'(9 - e);
            eb = 1'b1;
        end else begin
            er = 4'd10;
            eb = 1'b0;
        end
        chk("rk_idx", 128'(rk_idx), 128'(er));
        chk("busy", 128'(busy), 128'(eb));
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge while the DUT is idle; returns one cycle later with start dropped
    task automatic send(input logic [127:0] key, input logic [127:0] ct, input logic [127:0] pt);
        exp_t ex;
        expand(key);
        in_blk   = ct;
        start    = 1'b1;
        ex.due   = cyc + 11;
        ex.pt    = pt;
        q.push_back(ex);
        inflight = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [127:0] rkey;
        logic [127:0] rct;
        init_tables();
        for (int k = 0; k < 16; k++) keys[k] = 128'h0;
        rst    = 1'b1;
        start  = 1'b0;
        in_blk = 128'h0;
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(2);

        send(C1_KEY, C1_CT, C1_PT);
        wait_cyc(12);

        send(B_KEY, B_CT, B_PT);
        wait_cyc(12);

        // Busy rejection: second start at E3 with a different block
        send(C1_KEY, C1_CT, C1_PT);
        wait_cyc(2);
        in_blk = B_CT;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(11);

        // Back-to-back: next start in the done cycle
        send(C1_KEY, C1_CT, C1_PT);
        wait_cyc(10);
        send(B_KEY, B_CT, B_PT);
        wait_cyc(12);

        // Reset asserted for edge E5 of a block
        send(C1_KEY, C1_CT, C1_PT);
        wait_cyc(4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(14);
        send(C1_KEY, C1_CT, C1_PT);
        wait_cyc(12);

        for (int n = 0; n < 1000; n++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            rct  = {$urandom, $urandom, $urandom, $urandom};
            expand(rkey);
            send(rkey, rct, ref_decrypt(rct));
            wait_cyc(10 + int'($urandom_range(0, 2)));
        end

        wait_cyc(15);
        chk("scoreboard_empty", 128'(q.size()), 128'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
